cache_2way_ctrl: RTL and testbench
==================================

Name: cache_2way_ctrl

Overview:
- Write-back, write-allocate miss controller for the 2-way, 32-set, 64-bit-line cache; one line holds one word.
- Sits between the CPU load/store port, the cache array and the unified memory port.
- Sequences hit, writeback and fill, and drives the cache array's write-enable, dirty and LRU-toggle controls.
- Keeps saturating hit and miss counters for performance reporting.

Parameters:
- ADDR_W, 14, word address width; tag is addr[13:5], index is addr[4:0].
- DATA_W, 64, line/word width.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset
- cpu_addr  in  ADDR_W  request address
- cpu_re  in  1  read request; held until cpu_rdy
- cpu_we  in  1  write request; held until cpu_rdy
- cpu_wr_data  in  DATA_W  store data
- cpu_rdy  out  1  one-cycle completion pulse
- cpu_rd_data  out  DATA_W  load data; valid while cpu_rdy=1
- c_addr  out  ADDR_W  cache array address
- c_re  out  1  cache read enable
- c_we  out  1  cache write enable
- c_wr_data  out  DATA_W  cache write data
- c_wdirty  out  1  dirty bit written with the line
- c_toggle  out  1  flip the set's LRU bit on this write
- c_rd_data  in  DATA_W  cache line data
- c_tag_out  in  9  tag of the selected/victim line
- c_hit  in  1  tag match
- c_dirty  in  1  selected/victim line is valid and dirty
- m_addr  out  ADDR_W  memory address
- m_re  out  1  memory read; held until m_rdy
- m_we  out  1  memory write; held until m_rdy
- m_wr_data  out  DATA_W  writeback data
- m_rd_data  in  DATA_W  fill data; valid while m_rdy=1
- m_rdy  in  1  memory completion pulse
- hit_cnt  out  CNT_W  saturating hit count
- miss_cnt  out  CNT_W  saturating miss count

Behaviour:
- Reset: rst_n is asynchronous, active-low. All outputs and counters go to 0 and the FSM goes to IDLE, including mid-transaction. An outstanding memory access is abandoned and the memory is expected to be reset with the controller.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL, RESP.
- IDLE: when cpu_re|cpu_we is high at an edge, latch addr, wr_data and the op (write wins if both are high) and go to COMPARE.
- COMPARE: c_re=1, c_addr=latched addr.
  - Hit + read: latch c_rd_data, increment hit_cnt, go to RESP.
  - Hit + write: c_we=1, c_wr_data=latched data, c_wdirty=1, c_toggle=0; increment hit_cnt; go to RESP.
  - Miss: increment miss_cnt. If c_dirty=1, go to WRITEBACK and register the victim as m_addr={c_tag_out,index} and m_wr_data=c_rd_data. Otherwise go to ALLOCATE.
- WRITEBACK: m_we=1 held at a stable address and data; on m_rdy go to ALLOCATE.
- ALLOCATE: m_re=1, m_addr=latched addr; on m_rdy latch m_rd_data and go to FILL.
- FILL: one cycle with c_we=1 and c_toggle=1.
  - Write op: c_wr_data=CPU data, c_wdirty=1.
  - Read op: c_wr_data=memory data, c_wdirty=0.
  - Then go to RESP.
- RESP: cpu_rdy=1 for exactly one cycle. cpu_rd_data holds the hit or fill data for reads and 0 for writes. Return to IDLE; a new request may be accepted at the next edge.
- Latency: request sampled at edge N gives cpu_rdy in cycle N+2 on a hit. A clean miss takes N+3 plus the memory latency. A dirty miss adds one more memory access.
- m_re and m_we are never both asserted. c_we is asserted in at most one cycle per transaction.
- Counters saturate at all-ones and do not wrap.
- An m_rdy arriving in any state other than WRITEBACK or ALLOCATE is ignored.
- CPU address/data changes while busy are ignored; the latched copy is used.

Decomposition:
- Shared package cache_pkg holds TAG_W=9, IDX_W=5, DATA_W=64, the ctrl_state_e enum, and the tag/index extraction functions.
- One sub-module, sat_counter (CNT_W, inc, clr), is instantiated twice for hit_cnt and miss_cnt.

Test Plan:
- Read miss on a clean set, addr=0x0A3 with memory returning 0xDEAD_BEEF after 3 cycles -> m_re with m_addr=0x0A3, a FILL write with c_toggle=1 and c_wdirty=0, cpu_rdy with data 0xDEAD_BEEF; miss_cnt=1.
- Repeat the read of 0x0A3 with c_hit=1 -> cpu_rdy exactly 2 cycles after the request with the cached data, no memory activity; hit_cnt=1.
- Write hit to 0x0A3 with data 0x1234 -> a single c_we cycle with c_wdirty=1 and c_toggle=0, cpu_rdy, and m_we never asserted.
- Miss with c_dirty=1, c_tag_out=0x1FF, addr=0x0C3 -> m_we at 0x3FE3 first, then after m_rdy m_re at 0x0C3, then FILL and RESP; m_re and m_we never overlap.
- rst_n low while in ALLOCATE -> all outputs 0 immediately; after release a new request is served normally.
- 65540 forced hits with CNT_W=16 -> hit_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM state type and address helpers for the 2-way cache controller.
// Rev 1.0
`default_nettype none

package cache_pkg;

  localparam int TAG_W  = 9;
  localparam int IDX_W  = 5;
  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COMPARE   = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_ALLOCATE  = 3'd3,
    ST_FILL      = 3'd4,
    ST_RESP      = 3'd5
  } ctrl_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [TAG_W+IDX_W-1:0] addr);
    return addr[TAG_W+IDX_W-1:IDX_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [TAG_W+IDX_W-1:0] addr);
    return addr[IDX_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; synchronous clear.
// Rev 1.0
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cache_2way_ctrl.sv
// cache_2way_ctrl: write-back / write-allocate miss controller for a 2-way, 32-set, one-word-line cache.
// Rev 1.0
`default_nettype none

module cache_2way_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          cpu_addr_i,
  input  logic                       cpu_re_i,
  input  logic                       cpu_we_i,
  input  logic [DATA_W-1:0]          cpu_wr_data_i,
  output logic                       cpu_rdy_o,
  output logic [DATA_W-1:0]          cpu_rd_data_o,
  output logic [ADDR_W-1:0]          c_addr_o,
  output logic                       c_re_o,
  output logic                       c_we_o,
  output logic [DATA_W-1:0]          c_wr_data_o,
  output logic                       c_wdirty_o,
  output logic                       c_toggle_o,
  input  logic [DATA_W-1:0]          c_rd_data_i,
  input  logic [cache_pkg::TAG_W-1:0] c_tag_out_i,
  input  logic                       c_hit_i,
  input  logic                       c_dirty_i,
  output logic [ADDR_W-1:0]          m_addr_o,
  output logic                       m_re_o,
  output logic                       m_we_o,
  output logic [DATA_W-1:0]          m_wr_data_o,
  input  logic [DATA_W-1:0]          m_rd_data_i,
  input  logic                       m_rdy_i,
  output logic [CNT_W-1:0]           hit_cnt_o,
  output logic [CNT_W-1:0]           miss_cnt_o
);

  import cache_pkg::*;

  ctrl_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                hit_inc, miss_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      data_q    <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      data_q    <= data_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    is_wr_d       = is_wr_q;
    data_d        = data_q;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    cpu_rdy_o     = 1'b0;
    cpu_rd_data_o = '0;
    c_addr_o      = '0;
    c_re_o        = 1'b0;
    c_we_o        = 1'b0;
    c_wr_data_o   = '0;
    c_wdirty_o    = 1'b0;
    c_toggle_o    = 1'b0;
    m_addr_o      = '0;
    m_re_o        = 1'b0;
    m_we_o        = 1'b0;
    m_wr_data_o   = '0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_re_i || cpu_we_i) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wr_data_i;
          is_wr_d = cpu_we_i;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        c_re_o   = 1'b1;
        c_addr_o = addr_q;
        if (c_hit_i) begin
          hit_inc = 1'b1;
          if (is_wr_q) begin
            c_we_o      = 1'b1;
            c_wr_data_o = wdata_q;
            c_wdirty_o  = 1'b1;
          end else begin
            data_d = c_rd_data_i;
          end
          state_d = ST_RESP;
        end else begin
          miss_inc = 1'b1;
          // Victim is captured here so the writeback address/data stay stable while m_we is held.
          if (c_dirty_i) begin
            wb_addr_d = {c_tag_out_i, addr_idx(addr_q)};
            wb_data_d = c_rd_data_i;
            state_d   = ST_WRITEBACK;
          end else begin
            state_d = ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        m_we_o      = 1'b1;
        m_addr_o    = wb_addr_q;
        m_wr_data_o = wb_data_q;
        if (m_rdy_i) state_d = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        m_re_o   = 1'b1;
        m_addr_o = addr_q;
        if (m_rdy_i) begin
          data_d  = m_rd_data_i;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        c_we_o      = 1'b1;
        c_toggle_o  = 1'b1;
        c_addr_o    = addr_q;
        c_wr_data_o = is_wr_q ? wdata_q : data_q;
        c_wdirty_o  = is_wr_q;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        cpu_rdy_o     = 1'b1;
        cpu_rd_data_o = is_wr_q ? '0 : data_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (hit_inc),
    .clr_i (1'b0),
    .cnt_o (hit_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (miss_inc),
    .clr_i (1'b0),
    .cnt_o (miss_cnt_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_cache_2way_ctrl.sv
// tb_cache_2way_ctrl: drives the controller against a 2-way cache array model, a latency memory and a flat golden memory.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_cache_2way_ctrl;

  localparam int AW = 14;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cpu_addr;
  logic          cpu_re, cpu_we;
  logic [DW-1:0] cpu_wr_data;
  logic          cpu_rdy;
  logic [DW-1:0] cpu_rd_data;
  logic [AW-1:0] c_addr;
  logic          c_re, c_we, c_wdirty, c_toggle;
  logic [DW-1:0] c_wr_data;
  logic [DW-1:0] c_rd_data;
  logic [8:0]    c_tag_out;
  logic          c_hit, c_dirty;
  logic [AW-1:0] m_addr;
  logic          m_re, m_we;
  logic [DW-1:0] m_wr_data;
  logic [DW-1:0] m_rd_data;
  logic          m_rdy;
  logic [CW-1:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_2way_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_addr_i    (cpu_addr),
    .cpu_re_i      (cpu_re),
    .cpu_we_i      (cpu_we),
    .cpu_wr_data_i (cpu_wr_data),
    .cpu_rdy_o     (cpu_rdy),
    .cpu_rd_data_o (cpu_rd_data),
    .c_addr_o      (c_addr),
    .c_re_o        (c_re),
    .c_we_o        (c_we),
    .c_wr_data_o   (c_wr_data),
    .c_wdirty_o    (c_wdirty),
    .c_toggle_o    (c_toggle),
    .c_rd_data_i   (c_rd_data),
    .c_tag_out_i   (c_tag_out),
    .c_hit_i       (c_hit),
    .c_dirty_i     (c_dirty),
    .m_addr_o      (m_addr),
    .m_re_o        (m_re),
    .m_we_o        (m_we),
    .m_wr_data_o   (m_wr_data),
    .m_rd_data_i   (m_rd_data),
    .m_rdy_i       (m_rdy),
    .hit_cnt_o     (hit_cnt),
    .miss_cnt_o    (miss_cnt)
  );

  // Cache array model: lru[set] names the way to replace next.
  logic [8:0]    tg  [0:31][0:1];
  logic          vl  [0:31][0:1];
  logic          dr  [0:31][0:1];
  logic [DW-1:0] cd  [0:31][0:1];
  logic          lru [0:31];
  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] gold [0:(1<<AW)-1];

  logic [4:0] rix;
  int         rw;
  always_comb begin
    rix   = c_addr[4:0];
    rw    = int'(lru[rix]);
    c_hit = 1'b0;
    if (vl[rix][0] && tg[rix][0] == c_addr[13:5]) begin
      c_hit = 1'b1; rw = 0;
    end else if (vl[rix][1] && tg[rix][1] == c_addr[13:5]) begin
      c_hit = 1'b1; rw = 1;
    end
    c_rd_data = cd[rix][rw];
    c_tag_out = tg[rix][rw];
    c_dirty   = vl[rix][rw] & dr[rix][rw];
  end

  int checks = 0;
  int failures = 0;
  int ehits, emiss;
  int mcnt, mlat, ncyc, nwe;
  bit overlap, mact, got_rdy, last_tog, last_wd;
  logic [DW-1:0] rdy_data;
  logic [AW:0]   mops[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int way_of(input logic [AW-1:0] a);
    for (int w = 0; w < 2; w++)
      if (vl[a[4:0]][w] && tg[a[4:0]][w] == a[13:5]) return w;
    return -1;
  endfunction

  function automatic logic [CW-1:0] sat(input int v);
    return (v > int'(CMAX)) ? CMAX : CW'(v);
  endfunction

  // One negedge: observe the DUT, run the memory responder and apply cache-array writes.
  task automatic tick();
    int w;
    logic [4:0] ix;
    @(negedge clk);
    ncyc++;
    if (m_re && m_we) overlap = 1'b1;
    if (m_re || m_we) mact = 1'b1;
    if (m_rdy) begin
      m_rdy = 1'b0; m_rd_data = '0; mcnt = -1;
    end
    if (mcnt < 0 && (m_re || m_we)) begin
      mcnt = mlat;
      mops.push_back({m_we, m_addr});
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        m_rdy = 1'b1;
        if (m_we) mem[m_addr] = m_wr_data;
        else      m_rd_data   = mem[m_addr];
      end
    end
    if (c_we) begin
      nwe++;
      ix = c_addr[4:0];
      if (c_toggle) begin
        w = int'(lru[ix]);
        tg[ix][w] = c_addr[13:5];
        vl[ix][w] = 1'b1;
        lru[ix]   = ~lru[ix];
      end else begin
        w = way_of(c_addr);
        if (w < 0) w = 0;
      end
      dr[ix][w] = c_wdirty;
      cd[ix][w] = c_wr_data;
      last_tog  = c_toggle;
      last_wd   = c_wdirty;
    end
    if (cpu_rdy) begin
      got_rdy  = 1'b1;
      rdy_data = cpu_rd_data;
    end
  endtask

  task automatic do_op(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int lat, input string tag);
    int w, ecyc;
    bit hit, dv;
    logic [4:0] ix;
    logic [DW-1:0] exp_rd;
    tick();
    ix     = a[4:0];
    w      = way_of(a);
    hit    = (w >= 0);
    dv     = !hit && vl[ix][lru[ix]] && dr[ix][lru[ix]];
    ecyc   = hit ? 2 : (dv ? 5 + 2*lat : 4 + lat);
    exp_rd = wr ? '0 : gold[a];
    if (hit) ehits++; else emiss++;
    nwe = 0; overlap = 1'b0; mact = 1'b0; got_rdy = 1'b0; ncyc = 0; mlat = lat;
    mops.delete();
    cpu_addr = a; cpu_wr_data = d; cpu_we = wr; cpu_re = !wr;
    tick();
    cpu_addr    = AW'($urandom);
    cpu_wr_data = {$urandom, $urandom};
    while (!got_rdy && ncyc < 80) tick();
    cpu_re = 1'b0; cpu_we = 1'b0;
    if (wr) gold[a] = d;
    chk({tag, ":rdy"}, 64'(got_rdy), 64'd1);
    chk({tag, ":cycles"}, 64'(ncyc), 64'(ecyc));
    chk({tag, ":c_we_count"}, 64'(nwe), (hit && !wr) ? 64'd0 : 64'd1);
    chk({tag, ":mem_activity"}, 64'(mact), 64'(!hit));
    chk({tag, ":m_re_m_we_overlap"}, 64'(overlap), 64'd0);
    chk({tag, ":rd_data"}, rdy_data, exp_rd);
    chk({tag, ":hit_cnt"}, 64'(hit_cnt), 64'(sat(ehits)));
    chk({tag, ":miss_cnt"}, 64'(miss_cnt), 64'(sat(emiss)));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cpu_re = 1'b0; cpu_we = 1'b0;
    m_rdy = 1'b0; m_rd_data = '0; mcnt = -1;
    tick(); tick();
    rst_n = 1'b1;
    ehits = 0; emiss = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wr_data = '0;
    m_rdy = 1'b0; m_rd_data = '0; mcnt = -1; mlat = 1;
    ehits = 0; emiss = 0; ncyc = 0; nwe = 0;
    for (int s = 0; s < 32; s++) begin
      lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        tg[s][w] = '0; vl[s][w] = 1'b0; dr[s][w] = 1'b0; cd[s][w] = '0;
      end
    end
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i]  = {32'(i) ^ 32'h1357_9BDF, 32'(i) * 32'h9E37_79B1};
      gold[i] = mem[i];
    end
    mem[14'h0A3]  = 64'hDEAD_BEEF;
    gold[14'h0A3] = 64'hDEAD_BEEF;
    tick(); tick();
    chk("reset:cpu_rdy", 64'(cpu_rdy), 64'd0);
    chk("reset:ctrl", 64'({c_re, c_we, m_re, m_we}), 64'd0);
    chk("reset:counts", 64'({hit_cnt, miss_cnt}), 64'd0);
    rst_n = 1'b1;

    // Clean read miss, then hit, then write hit on the same word.
    do_op(1'b0, 14'h0A3, '0, 3, "rd_miss");
    chk("rd_miss:mem_op", mops.size() > 0 ? 64'(mops[0]) : '1, 64'({1'b0, 14'h0A3}));
    chk("rd_miss:fill_toggle", 64'(last_tog), 64'd1);
    chk("rd_miss:fill_wdirty", 64'(last_wd), 64'd0);
    chk("rd_miss:miss_cnt1", 64'(miss_cnt), 64'd1);
    do_op(1'b0, 14'h0A3, '0, 3, "rd_hit");
    chk("rd_hit:hit_cnt1", 64'(hit_cnt), 64'd1);
    do_op(1'b1, 14'h0A3, 64'h1234, 3, "wr_hit");
    chk("wr_hit:toggle", 64'(last_tog), 64'd0);
    chk("wr_hit:wdirty", 64'(last_wd), 64'd1);
    do_op(1'b0, 14'h0A3, '0, 2, "rd_after_wr");

    // Dirty victim with tag 0x1FF in set 3.
    lru[3] = 1'b1;
    tg[3][1] = 9'h1FF; vl[3][1] = 1'b1; dr[3][1] = 1'b1; cd[3][1] = 64'hCAFE;
    gold[14'h3FE3] = 64'hCAFE;
    do_op(1'b0, 14'h0C3, '0, 2, "dirty_miss");
    chk("dirty_miss:op_count", 64'(mops.size()), 64'd2);
    chk("dirty_miss:op0", mops.size() > 0 ? 64'(mops[0]) : '1, 64'({1'b1, 14'h3FE3}));
    chk("dirty_miss:op1", mops.size() > 1 ? 64'(mops[1]) : '1, 64'({1'b0, 14'h0C3}));
    chk("dirty_miss:wb_data", mem[14'h3FE3], 64'hCAFE);

    // Reset while waiting on a fill.
    tick();
    mlat = 20; mops.delete(); mact = 1'b0;
    cpu_addr = 14'h155; cpu_re = 1'b1;
    for (int i = 0; i < 10 && !m_re; i++) tick();
    chk("rst_alloc:m_re_seen", 64'(m_re), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_alloc:ctrl", 64'({cpu_rdy, c_re, c_we, c_toggle, c_wdirty, m_re, m_we}), 64'd0);
    chk("rst_alloc:m_addr", 64'(m_addr), 64'd0);
    chk("rst_alloc:c_addr", 64'(c_addr), 64'd0);
    chk("rst_alloc:cpu_rd_data", cpu_rd_data, 64'd0);
    chk("rst_alloc:counts", 64'({hit_cnt, miss_cnt}), 64'd0);
    cpu_re = 1'b0; m_rdy = 1'b0; m_rd_data = '0; mcnt = -1;
    tick(); tick();
    rst_n = 1'b1;
    ehits = 0; emiss = 0;
    do_op(1'b0, 14'h155, '0, 2, "post_rst");

    // Randomized traffic over 4 tags x 4 sets to force hits, clean and dirty evictions.
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] ra;
      ra = {7'd0, 2'($urandom), 3'd0, 2'($urandom)};
      do_op(1'($urandom), ra, {$urandom, $urandom}, int'($urandom_range(1, 4)), "rand");
    end
    do_op(1'b0, 14'h3FE3, '0, 1, "rd_victim_back");

    // Saturation of the hit counter.
    pulse_reset();
    do_op(1'b0, 14'h0A3, '0, 1, "sat_warm");
    for (int n = 0; n < int'(CMAX) + 5; n++) do_op(1'b0, 14'h0A3, '0, 1, "sat");
    chk("sat:hit_cnt_max", 64'(hit_cnt), 64'(CMAX));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
